data_mem_bridge: RTL

Sits directly downstream of the five-stage core's MEM stage. It converts the core's single-cycle data-memory port into a valid/ready request/response bus to a slow data memory. Stores are posted through a one-entry write buffer. Loads stall the core via data_mem_hazard until the response returns, and the returned word is presented on data_mem_rdata in the cycle the stall drops, so the MEM/WB register captures it on that edge.

---
 rtl/data_mem_bridge_pkg.sv | 22 ++
 rtl/data_mem_bridge_write_buffer.sv | 37 +++
 rtl/data_mem_bridge.sv | 134 +++++++++++++
 3 files changed

// File: rtl/data_mem_bridge_pkg.sv
// Shared types and constants for the core data-memory bridge.
package data_mem_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        RD_DONE = 3'd4
    } bridge_state_e;

    localparam logic MEM_OP_READ  = 1'b0;
    localparam logic MEM_OP_WRITE = 1'b1;

    localparam int unsigned DEFAULT_DATA_WIDTH      = 32;
    localparam int unsigned DEFAULT_DATA_ADDR_WIDTH = 32;

    function automatic int unsigned strobe_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/data_mem_bridge_write_buffer.sv
// One-entry posted-store buffer: loads a store, holds it until the bus drain handshake.
module data_write_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [STRB_WIDTH-1:0] load_strobe,
    input  logic                  drain,
    output logic                  valid,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic [STRB_WIDTH-1:0] strobe
);

    // Contents are only written while empty, so they stay stable during a drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= 1'b0;
            addr   <= '0;
            data   <= '0;
            strobe <= '0;
        end else if (drain) begin
            valid <= 1'b0;
        end else if (load && !valid) begin
            valid  <= 1'b1;
            addr   <= load_addr;
            data   <= load_data;
            strobe <= load_strobe;
        end
    end

endmodule

// File: rtl/data_mem_bridge.sv
// Bridges the core's single-cycle MEM-stage data port onto a valid/ready memory bus,
// posting stores through a one-entry buffer and stalling loads until data returns.
module data_mem_bridge
    import data_mem_bridge_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int unsigned DATA_ADDR_WIDTH = DEFAULT_DATA_ADDR_WIDTH
) (
    input  logic                       cpu_clk,
    input  logic                       cpu_rst,
    input  logic                       cpu_data_mem_read,
    input  logic [DATA_ADDR_WIDTH-1:0] cpu_data_mem_raddr,
    input  logic                       cpu_data_mem_write,
    input  logic [DATA_ADDR_WIDTH-1:0] cpu_data_mem_waddr,
    input  logic [DATA_WIDTH-1:0]      cpu_data_mem_wdata,
    input  logic [DATA_WIDTH/8-1:0]    cpu_data_mem_write_strobe,
    output logic [DATA_WIDTH-1:0]      data_mem_rdata,
    output logic                       data_mem_hazard,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic                       mem_req_write,
    output logic [DATA_ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0]      mem_req_wdata,
    output logic [DATA_WIDTH/8-1:0]    mem_req_strobe,
    input  logic                       mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]      mem_rsp_rdata
);

    localparam int unsigned STRB_WIDTH = strobe_width(DATA_WIDTH);
    localparam logic [DATA_ADDR_WIDTH-1:0] WORD_MASK = ~DATA_ADDR_WIDTH'(3);

    bridge_state_e                state;
    logic                         req_valid_q;
    logic                         req_write_q;
    logic [DATA_ADDR_WIDTH-1:0]   raddr_q;
    logic [DATA_WIDTH-1:0]        rdata_q;

    logic                         wbuf_valid;
    logic [DATA_ADDR_WIDTH-1:0]   wbuf_addr;
    logic [DATA_WIDTH-1:0]        wbuf_data;
    logic [STRB_WIDTH-1:0]        wbuf_strobe;

    logic                         wbuf_load;
    logic                         wbuf_drain;
    logic                         load_req;

    // A simultaneous read+write is handled purely as a store.
    assign load_req   = cpu_data_mem_read & ~cpu_data_mem_write;
    assign wbuf_load  = cpu_data_mem_write & ~wbuf_valid;
    assign wbuf_drain = (state == WR_REQ) & mem_req_ready;

    data_write_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (DATA_ADDR_WIDTH),
        .STRB_WIDTH (STRB_WIDTH)
    ) u_wbuf (
        .clk         (cpu_clk),
        .rst         (cpu_rst),
        .load        (wbuf_load),
        .load_addr   (cpu_data_mem_waddr & WORD_MASK),
        .load_data   (cpu_data_mem_wdata),
        .load_strobe (cpu_data_mem_write_strobe),
        .drain       (wbuf_drain),
        .valid       (wbuf_valid),
        .addr        (wbuf_addr),
        .data        (wbuf_data),
        .strobe      (wbuf_strobe)
    );

    // Buffer drain always wins over a new load so stores reach memory first.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state       <= IDLE;
            req_valid_q <= 1'b0;
            req_write_q <= MEM_OP_READ;
            raddr_q     <= '0;
            rdata_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wbuf_valid) begin
                        state       <= WR_REQ;
                        req_valid_q <= 1'b1;
                        req_write_q <= MEM_OP_WRITE;
                    end else if (load_req) begin
                        state       <= RD_REQ;
                        req_valid_q <= 1'b1;
                        req_write_q <= MEM_OP_READ;
                        raddr_q     <= cpu_data_mem_raddr & WORD_MASK;
                    end
                end
                WR_REQ: begin
                    if (mem_req_ready) begin
                        state       <= IDLE;
                        req_valid_q <= 1'b0;
                        req_write_q <= MEM_OP_READ;
                    end
                end
                RD_REQ: begin
                    if (mem_req_ready) begin
                        state       <= RD_WAIT;
                        req_valid_q <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (mem_rsp_valid) begin
                        state   <= RD_DONE;
                        rdata_q <= mem_rsp_rdata;
                    end
                end
                RD_DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    req_valid_q <= 1'b0;
                    req_write_q <= MEM_OP_READ;
                end
            endcase
        end
    end

    assign mem_req_valid  = req_valid_q;
    assign mem_req_write  = req_write_q;
    assign mem_req_addr   = req_write_q ? wbuf_addr : raddr_q;
    assign mem_req_wdata  = wbuf_data;
    assign mem_req_strobe = req_write_q ? wbuf_strobe : '0;
    assign data_mem_rdata = rdata_q;

    // Stall: store behind an undrained store, or a load not yet in its delivery cycle.
    assign data_mem_hazard = (cpu_data_mem_write & wbuf_valid)
                           | (load_req & (state != RD_DONE));

endmodule
